// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// It runs a shift-add multiply or a restoring divide, one bit per cycle, and the pipeline stalls on busy.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic div;
    logic neg_res;
    logic neg_rem;
    logic b_zero;
  } ctl_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  ctl_t              ctl;
  logic [WIDTH-1:0]  a_q, b_q, raw_a;
  logic [WIDTH-1:0]  acc, mq;
  logic              accept, last;

  logic              sgn, a_neg, b_neg;
  logic [WIDTH-1:0]  a_abs, b_abs;

  assign sgn   = ~op[0];
  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];
  assign a_abs = a_neg ? -src_a : src_a;
  assign b_abs = b_neg ? -src_b : src_b;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !cancel) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CALC && !cancel && cnt != LAST) ? cnt + 6'd1 : 6'd0;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // One iteration. acc is the product high half or the partial remainder.
  // mq shifts the multiplier out, or shifts dividend bits out while quotient bits shift in.
  logic [WIDTH:0]    sum, sh;
  logic [WIDTH+1:0]  diff;
  logic              q_bit;
  logic [WIDTH-1:0]  acc_nxt, mq_nxt;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, (mq[0] ? a_q : {WIDTH{1'b0}})};
    sh    = {acc, mq[WIDTH-1]};
    diff  = {1'b0, sh} - {2'b00, b_q};
    q_bit = ~diff[WIDTH+1];
    if (ctl.div) begin
      acc_nxt = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      mq_nxt  = {mq[WIDTH-2:0], q_bit};
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod   = {acc_nxt, mq_nxt};
    prod_c = ctl.neg_res ? -prod : prod;
    if (!ctl.div) begin
      res_hi = prod_c[2*WIDTH-1:WIDTH];
      res_lo = prod_c[WIDTH-1:0];
    end else if (ctl.b_zero) begin
      // Divide by zero returns the dividend as it was presented, sign untouched.
      res_hi = raw_a;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = ctl.neg_rem ? -acc_nxt : acc_nxt;
      res_lo = ctl.neg_res ? -mq_nxt  : mq_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      raw_a <= '0;
      acc   <= '0;
      mq    <= '0;
    end else if (accept) begin
      ctl.div     <= op[1];
      ctl.neg_res <= a_neg ^ b_neg;
      ctl.neg_rem <= a_neg;
      ctl.b_zero  <= (src_b == '0);
      a_q         <= a_abs;
      b_q         <= b_abs;
      raw_a       <= src_a;
      acc         <= '0;
      mq          <= op[1] ? a_abs : b_abs;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
    end
  end

  // A result always wins over a move-to. Move-to writes are ignored while computing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (last) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state != CALC) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
